// File: rtl/ceespu_regfile_mp_if.sv
// Bus bundle for the multi-port register file: read selects/data, two write ports, status.
// master = decode/writeback side driving indices and write data, slave = the register file.
interface ceespu_regfile_mp_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int NUM_RD = 2
);
  logic [NUM_RD*ADDR_W-1:0] I_sel;
  logic [NUM_RD*DATA_W-1:0] O_data;
  logic                     I_weA;
  logic [ADDR_W-1:0]        I_selA;
  logic [DATA_W-1:0]        I_dataA;
  logic                     I_weB;
  logic [ADDR_W-1:0]        I_selB;
  logic [DATA_W-1:0]        I_dataB;
  logic                     O_busy;
  logic                     O_collide;

  modport master (
    output I_sel, I_weA, I_selA, I_dataA, I_weB, I_selB, I_dataB,
    input  O_data, O_busy, O_collide
  );

  modport slave (
    input  I_sel, I_weA, I_selA, I_dataA, I_weB, I_selB, I_dataB,
    output O_data, O_busy, O_collide
  );
endinterface

// File: rtl/ceespu_regfile_mp.sv
// Multi-port register file with two write ports; reads are combinational, writes land on the edge.
// No backpressure: O_busy stays high for DEPTH cycles after reset while the array is cleared.
module ceespu_regfile_mp #(
  parameter int                DATA_W   = 32,
  parameter int                ADDR_W   = 5,
  parameter int                NUM_RD   = 2,
  parameter int                ZERO_REG = 1,
  parameter int                BYPASS   = 1,
  parameter int                SP_IDX   = 18,
  parameter logic [DATA_W-1:0] SP_INIT  = 'h0000fff0
) (
  input logic                  I_clk,
  input logic                  I_rst,
  ceespu_regfile_mp_if.slave   bus
);
  localparam int DEPTH = 2**ADDR_W;

  typedef enum logic {
    CLEAR = 1'b0,
    READY = 1'b1
  } state_t;

  state_t              state, stateNext;
  logic [ADDR_W-1:0]   cnt, cntNext;
  logic                collide, collideNext;
  logic [DATA_W-1:0]   mem [DEPTH];

  logic                ready;
  logic                weAEff;
  logic                weBEff;
  logic                sameIdx;
  logic [DATA_W-1:0]   clearVal;

  assign ready    = (state == READY);
  // Effective enables already fold in the clear lockout and the hardwired zero register.
  assign weAEff   = ready && bus.I_weA && !((ZERO_REG != 0) && (bus.I_selA == '0));
  assign weBEff   = ready && bus.I_weB && !((ZERO_REG != 0) && (bus.I_selB == '0));
  assign sameIdx  = (bus.I_selA == bus.I_selB);
  assign clearVal = (cnt == ADDR_W'(SP_IDX)) ? SP_INIT : '0;

  always_ff @(posedge I_clk) begin
    if (I_rst) begin
      state   <= CLEAR;
      cnt     <= '0;
      collide <= 1'b0;
    end else begin
      state   <= stateNext;
      cnt     <= cntNext;
      collide <= collideNext;
    end
  end

  always_comb begin
    stateNext   = state;
    cntNext     = cnt;
    collideNext = 1'b0;
    case (state)
      CLEAR: begin
        cntNext = cnt + 1'b1;
        if (cnt == ADDR_W'(DEPTH - 1)) begin
          stateNext = READY;
        end
      end
      READY: begin
        collideNext = weAEff && weBEff && sameIdx;
      end
      default: begin
        stateNext = CLEAR;
        cntNext   = '0;
      end
    endcase
  end

  // Port B is written last so it owns a shared index.
  always_ff @(posedge I_clk) begin
    if (!I_rst) begin
      if (!ready) begin
        mem[cnt] <= clearVal;
      end else begin
        if (weAEff && !(weBEff && sameIdx)) begin
          mem[bus.I_selA] <= bus.I_dataA;
        end
        if (weBEff) begin
          mem[bus.I_selB] <= bus.I_dataB;
        end
      end
    end
  end

  assign bus.O_busy    = !ready;
  assign bus.O_collide = collide;

  for (genvar k = 0; k < NUM_RD; k++) begin : gRd
    logic [ADDR_W-1:0] rs;
    logic [DATA_W-1:0] rd;

    assign rs = bus.I_sel[k*ADDR_W +: ADDR_W];

    always_comb begin
      rd = mem[rs];
      if (!ready || ((ZERO_REG != 0) && (rs == '0))) begin
        rd = '0;
      end else if ((BYPASS != 0) && weBEff && (bus.I_selB == rs)) begin
        rd = bus.I_dataB;
      end else if ((BYPASS != 0) && weAEff && (bus.I_selA == rs)) begin
        rd = bus.I_dataA;
      end
    end

    assign bus.O_data[k*DATA_W +: DATA_W] = rd;
  end
endmodule
